// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the Avalon-MM master port.
// State encoding and bus widths used by the FSM, interface and bench.
package avalon_mm_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/avalon_mm_master_port_if.sv
// Core request/response and Avalon-MM signals of the master port.
// master = the port itself, slave = core plus Avalon fabric around it.
interface avalon_mm_master_port_if #(
  parameter int ADDR_W = 32
);
  import avalon_mm_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [BE_W-1:0]   avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_be,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output avm_address, avm_read, avm_write,
    output avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_wdata, req_be,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  avm_address, avm_read, avm_write,
    input  avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/avmm_timeout_counter.sv
// Watchdog for a bus transaction: expired is high in the TIMEOUT-th
// enabled cycle since the last clear.
module avmm_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  assign expired = enable && (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/avalon_mm_master_port.sv
// Single-beat Avalon-MM initiator for core loads/stores, with a
// watchdog that turns a hung slave into an error response.
module avalon_mm_master_port
  import avalon_mm_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input logic                   clk,
  input logic                   reset,
  avalon_mm_master_port_if.master bus
);

  state_e r_state;
  state_e w_nxt;

  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_error;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_read;
  logic              r_write;

  logic              w_accept;
  logic              w_busy;
  logic              w_expired;
  logic              w_set_rsp;
  logic              w_err;
  logic [DATA_W-1:0] w_rdata;
  logic              w_wr;
  logic              w_rdv;

  assign w_wr     = bus.avm_waitrequest;
  assign w_rdv    = bus.avm_readdatavalid;
  assign w_accept = (r_state == IDLE) && bus.req_valid;
  assign w_busy   = (r_state == WRITE) || (r_state == READ) ||
                    (r_state == READ_WAIT);

  avmm_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept),
    .enable  (w_busy),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  // Completion is tested before expiry so it wins a same-cycle tie.
  always_comb begin
    w_nxt     = r_state;
    w_set_rsp = 1'b0;
    w_err     = 1'b0;
    w_rdata   = '0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) w_nxt = bus.req_write ? WRITE : READ;
      end
      WRITE: begin
        if (!w_wr || w_expired) begin
          w_nxt     = RESP;
          w_set_rsp = 1'b1;
          w_err     = w_wr;
        end
      end
      READ: begin
        if (!w_wr && w_rdv) begin
          w_nxt     = RESP;
          w_set_rsp = 1'b1;
          w_rdata   = bus.avm_readdata;
        end else if (w_expired) begin
          w_nxt     = RESP;
          w_set_rsp = 1'b1;
          w_err     = 1'b1;
          w_rdata   = ERR_RDATA;
        end else if (!w_wr) begin
          w_nxt = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (w_rdv) begin
          w_nxt     = RESP;
          w_set_rsp = 1'b1;
          w_rdata   = bus.avm_readdata;
        end else if (w_expired) begin
          w_nxt     = RESP;
          w_set_rsp = 1'b1;
          w_err     = 1'b1;
          w_rdata   = ERR_RDATA;
        end
      end
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
    end else begin
      r_req_ready <= (w_nxt == IDLE);
      r_rsp_valid <= (w_nxt == RESP);
      r_read      <= (w_nxt == READ);
      r_write     <= (w_nxt == WRITE);
      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
      end
      if (w_set_rsp) begin
        r_rsp_rdata <= w_rdata;
        r_rsp_error <= w_err;
      end
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rsp_rdata;
  assign bus.rsp_error      = r_rsp_error;
  assign bus.avm_address    = r_addr;
  assign bus.avm_read       = r_read;
  assign bus.avm_write      = r_write;
  assign bus.avm_writedata  = r_wdata;
  assign bus.avm_byteenable = r_be;

endmodule

// File: tb/tb_avalon_mm_master_port.sv
// Bench for avalon_mm_master_port: memory-backed slave with random
// stalls, latency and stray readdatavalid against a cycle-count model.
module tb_avalon_mm_master_port;
  import avalon_mm_pkg::*;

  localparam int T = 8;
  localparam logic [31:0] ERRV = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  avalon_mm_master_port_if #(.ADDR_W(32)) bus ();

  avalon_mm_master_port #(
    .ADDR_W    (32),
    .TIMEOUT   (T),
    .ERR_RDATA (ERRV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: the transaction completes in cycle k after accept unless
  // k exceeds T, in which case it times out in cycle T; the response
  // pulse follows one cycle later.
  task automatic txn(input bit wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int ws, input int lat);
    int k, done, rsp_c, cmd_end;
    bit tmo;
    logic [31:0] exp_rd;
    k       = wr ? ws + 1 : ws + 1 + lat;
    tmo     = (k > T);
    done    = tmo ? T : k;
    rsp_c   = done + 1;
    cmd_end = (ws + 1 < T) ? ws + 1 : T;
    exp_rd  = wr ? 32'h0 : (tmo ? ERRV : mem[a]);

    check("ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = {28'h0, a};
    bus.req_wdata = wd;
    bus.req_be    = be;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;

    for (int c = 1; c <= rsp_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
      end
      check("rsp_valid", bus.rsp_valid, (c == rsp_c));
      check("req_busy", bus.req_ready, 0);
      check("avm_write", bus.avm_write, wr && c <= cmd_end);
      check("avm_read", bus.avm_read, !wr && c <= cmd_end);
      if (c <= cmd_end) begin
        check("avm_addr", bus.avm_address, {28'h0, a});
        check("avm_be", bus.avm_byteenable, be);
        if (wr) check("avm_wdata", bus.avm_writedata, wd);
      end
      if (c == rsp_c) begin
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("rsp_error", bus.rsp_error, tmo);
      end
      bus.avm_waitrequest = (c <= ws);
      if (!wr && c == k) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = mem[a];
      end else if (wr || c <= ws || c > done) begin
        bus.avm_readdatavalid = 1'($urandom);
        bus.avm_readdata      = $urandom;
      end else begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = $urandom;
      end
    end

    @(negedge clk);
    check("ready_back", bus.req_ready, 1);
    check("rsp_pulse", bus.rsp_valid, 0);
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest   = 1'b0;
    if (wr && !tmo) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[a][b*8 +: 8] = wd[b*8 +: 8];
    end
  endtask

  task automatic reset_mid_read();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h1;
    bus.avm_waitrequest = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    check("rst_pre_read", bus.avm_read, 1);
    reset = 1'b1;
    #1;
    check("rst_read", bus.avm_read, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h55AA55AA;
    for (int c = 0; c < T + 3; c++) begin
      @(negedge clk);
      bus.avm_readdatavalid = 1'b0;
      check("post_rst_rsp", bus.rsp_valid, 0);
      check("post_rst_rdy", bus.req_ready, 1);
      check("post_rst_rd", bus.avm_read, 0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    check("rst_avm_read", bus.avm_read, 0);
    check("rst_avm_write", bus.avm_write, 0);
    check("rst_avm_addr", bus.avm_address, 0);
    reset = 1'b0;
    @(negedge clk);

    txn(1, 4'd0, 32'h000000A5, 4'hF, 0, 0);
    txn(0, 4'd0, 32'h0, 4'hF, 0, 1);
    txn(0, 4'd1, 32'h0, 4'hF, 0, 1);
    txn(1, 4'd3, 32'h11223344, 4'hF, 3, 0);
    txn(1, 4'd2, 32'h12345678, 4'hF, 0, 0);
    txn(0, 4'd2, 32'h0, 4'hF, 0, 5);
    txn(1, 4'd4, 32'hCAFEF00D, 4'hF, 0, 0);
    txn(0, 4'd4, 32'h0, 4'hF, 0, 0);
    txn(0, 4'd4, 32'h0, 4'hF, 20, 0);
    txn(1, 4'd5, 32'h99999999, 4'hF, 20, 0);
    txn(1, 4'd6, 32'h0BADF00D, 4'h5, 7, 0);
    txn(1, 4'd6, 32'h0BADF00D, 4'hF, 8, 0);
    txn(0, 4'd6, 32'h0, 4'hF, 7, 0);
    txn(0, 4'd6, 32'h0, 4'hF, 2, 5);
    txn(0, 4'd6, 32'h0, 4'hF, 3, 5);

    for (int n = 0; n < 150; n++) begin
      txn(1'($urandom), 4'($urandom), $urandom, 4'($urandom),
          ($urandom % 8 == 0) ? $urandom_range(5, 12)
                              : int'($urandom % 3),
          int'($urandom % 6));
    end

    reset_mid_read();
    for (int n = 0; n < 20; n++) begin
      txn(1'($urandom), 4'($urandom), $urandom, 4'($urandom),
          int'($urandom % 3), int'($urandom % 4));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
